// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART receive path.
package uart_pkg;

    // Receiver FSM states; PARITY is only reachable when parity is compiled in.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rxState_t;

    // 50 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: holding-register handshake between the receiver and the
// command decoder. The receiver side is the master, the consumer the slave.
interface uart_rx_core_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

    logic [DATA_BITS-1:0] regOutput;
    logic                 dataValid;
    logic                 dataReady;
    logic                 frameErr;
    logic                 parityErr;
    logic                 overrun;

    modport master (
        output regOutput,
        output dataValid,
        output frameErr,
        output parityErr,
        output overrun,
        input  dataReady
    );

    modport slave (
        input  regOutput,
        input  dataValid,
        input  frameErr,
        input  parityErr,
        input  overrun,
        output dataReady
    );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for the asynchronous RX pin. Both flops
// reset to 1 so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic syncOut
);

    logic meta;

    // Two-stage capture of the raw line.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta    <= 1'b1;
            syncOut <= 1'b1;
        end else begin
            meta    <= asyncIn;
            syncOut <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: parametrised UART receiver with mid-bit sampling, valid/ready
// holding register and framing/parity/overrun status.
// Optional parity bit: define UART_RX_PARITY_EN to add the PARITY state.
//
// state  | meaning
// IDLE   | line idle, waiting for rxs to fall
// START  | timing half a bit to re-check the start bit at its centre
// DATA   | sampling DATA_BITS data bits, one per CLKS_PER_BIT
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, frame committed at the sample
// BREAK  | stop bit was low; waiting for the line to return high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int PARITY_ODD   = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           serialInput,
    uart_rx_core_if.master rxBus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    rxState_t             state;
    rxState_t             stateNext;
    logic                 rxs;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bitCnt;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 shiftEn;
    logic                 commit;
    logic                 cntClear;
    logic                 halfTc;
    logic                 fullTc;
    logic                 accept;
    logic                 parityErrNext;

    logic [DATA_BITS-1:0] regOutput;
    logic                 dataValid;
    logic                 frameErr;
    logic                 parityErr;
    logic                 overrun;

`ifdef UART_RX_PARITY_EN
    logic                 parityEn;
    logic                 parityBit;
`endif

    uart_rx_sync uSync (
        .clk     (clk),
        .rst     (rst),
        .asyncIn (serialInput),
        .syncOut (rxs)
    );

    assign halfTc = (cnt == HALF_TC);
    assign fullTc = (cnt == FULL_TC);
    assign accept = dataValid && rxBus.dataReady;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode and per-cycle sample/commit strobes.
    always_comb begin
        stateNext = state;
        shiftEn   = 1'b0;
        commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityEn  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) stateNext = START;
            end
            START: begin
                if (halfTc) stateNext = rxs ? IDLE : DATA;
            end
            DATA: begin
                if (fullTc) begin
                    shiftEn = 1'b1;
                    if (bitCnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (fullTc) begin
                    parityEn  = 1'b1;
                    stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (fullTc) begin
                    commit    = 1'b1;
                    stateNext = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Counter restarts on every state change and at each data-bit boundary;
    // held at zero while waiting on the line so it never wraps.
    assign cntClear = (stateNext != state) || shiftEn || (state == IDLE) || (state == BREAK);

    // Bit-period counter.
    always_ff @(posedge clk) begin
        if (rst || cntClear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Data-bit counter, only live in DATA.
    always_ff @(posedge clk) begin
        if (rst || (state != DATA)) begin
            bitCnt <= '0;
        end else if (shiftEn) begin
            bitCnt <= bitCnt + BIT_W'(1);
        end
    end

    // LSB-first shift register: each sample enters at the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftReg <= '0;
        end else if (shiftEn) begin
            shiftReg <= {rxs, shiftReg[DATA_BITS-1:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit for the frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            parityBit <= 1'b0;
        end else if (parityEn) begin
            parityBit <= rxs;
        end
    end

    assign parityErrNext = parityBit != ((^shiftReg) ^ (PARITY_ODD != 0));
`else
    // No parity bit on the line, so the parity sense has no effect.
    assign parityErrNext = 1'b0 && (PARITY_ODD != 0);
`endif

    // Holding register: load on commit when empty or being drained this cycle,
    // otherwise drop the frame and flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            regOutput <= '0;
            dataValid <= 1'b0;
            frameErr  <= 1'b0;
            parityErr <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (accept) overrun <= 1'b0;
            if (commit && (!dataValid || accept)) begin
                regOutput <= shiftReg;
                frameErr  <= !rxs;
                parityErr <= parityErrNext;
                dataValid <= 1'b1;
            end else if (commit) begin
                overrun <= 1'b1;
            end else if (accept) begin
                dataValid <= 1'b0;
            end
        end
    end

    assign rxBus.regOutput = regOutput;
    assign rxBus.dataValid = dataValid;
    assign rxBus.frameErr  = frameErr;
    assign rxBus.parityErr = parityErr;
    assign rxBus.overrun   = overrun;

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised UART receiver replacing the fixed 8-bit receiver in the line-follower serial path. It synchronises the asynchronous serial line, validates the start bit at mid-bit, and samples each data bit at its centre using a configurable clocks-per-bit divider. It delivers frames LSB-first through a valid/ready holding register, with framing, parity and overrun status. It sits between the board RX pin and the command decoder.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200); must be >= 4.
- `DATA_BITS`, default 8: data bits per frame, 5..9.
- `PARITY_ODD`, default 0: 0 = even parity, 1 = odd parity; used only when parity is compiled in.
- `clk`  in  1: single clock.
- `rst`  in  1: reset; synchronous, active-high.
- `serialInput`  in  1: asynchronous RX line; idles high.
- `regOutput`  out  DATA_BITS: received word; bit 0 is the first data bit on the line.
- `dataValid`  out  1: `regOutput` and the status bits hold an unconsumed frame.
- `dataReady`  in  1: consumer accepts the frame on a cycle where `dataValid && dataReady`.
- `frameErr`  out  1: the stop bit of the held frame sampled low.
- `parityErr`  out  1: the parity bit of the held frame mismatched.
- `overrun`  out  1: sticky; at least one frame was dropped because the holding register was full.

## Operation
- Input is double-flopped; all decisions use the synchronised line `rxs`.
- FSM states:
  - **IDLE**: if `rxs == 0`, go to START and clear the counter.
  - **START**: at count `CLKS_PER_BIT/2 - 1`, if `rxs == 0` go to DATA (this is the bit centre); otherwise return to IDLE as a glitch and deliver nothing.
  - **DATA**: every `CLKS_PER_BIT` cycles, shift `rxs` into the shift register from the MSB side. After `DATA_BITS` samples, go to PARITY if compiled in, else to STOP.
  - **PARITY**: sample one bit after `CLKS_PER_BIT` cycles; go to STOP.
  - **STOP**: sample after `CLKS_PER_BIT` cycles, then commit the frame.
    - Stop sampled 1: go to IDLE.
    - Stop sampled 0: go to BREAK.
  - **BREAK**: wait for `rxs == 1`, then go to IDLE. The errored frame has already been committed.
- Commit:
  - If `dataValid` is 0, or `dataValid && dataReady` in the same cycle, load `regOutput`, `frameErr` and `parityErr`, and set `dataValid`.
  - Otherwise drop the new frame and set `overrun`. Held data is not altered.
- Handshake: `dataValid` clears on `dataValid && dataReady` unless a commit occurs in that cycle.
  - `overrun` clears only on reset or an accepted handshake.
- Counter: `$clog2(CLKS_PER_BIT)` bits; reset to 0 on every state transition; no wrap inside a state.
- Bit counter: `$clog2(DATA_BITS+1)` bits.
- Reset mid-frame: the FSM returns to IDLE and the partial frame is discarded.
- Reset values: `regOutput` = 0, `dataValid` = 0, `frameErr` = 0, `parityErr` = 0, `overrun` = 0, FSM = IDLE. Synchroniser flops reset to 1.

## Timing
- Synchroniser latency: 2 cycles.
- Start-bit sample point: `CLKS_PER_BIT/2` cycles after `rxs` falls.
- Data bit n is sampled `(n+1)*CLKS_PER_BIT` cycles after the start sample.
- `dataValid` rises 1 cycle after the stop-bit sample.
- The receiver can accept back-to-back frames: it returns to IDLE at mid-stop, giving half a bit of slack for baud mismatch up to about ±4%.
- `dataReady` may be held high permanently.

## Configuration
- Macro `UART_RX_PARITY_EN`.
  - Defined: the PARITY state exists. The parity bit is checked against XOR of the data bits, XOR `PARITY_ODD`. A mismatch sets `parityErr` for that frame.
  - Undefined: the frame has no parity bit; STOP follows DATA directly; `parityErr` is tied to 0.

## Structure
- Package `uart_pkg`: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and the default `CLKS_PER_BIT`/`DATA_BITS` constants.
- Sub-module `uart_rx_sync`: 2-flop synchroniser with reset-to-1.

## Test plan
- `CLKS_PER_BIT=8`, `DATA_BITS=8`: send 0xA5 with stop 1 -> `regOutput` = 0xA5, `dataValid` = 1, `frameErr` = 0, `dataValid` rising 1 cycle after the mid-stop sample.
- Low pulse of 3 cycles on an idle line -> FSM returns to IDLE, `dataValid` stays 0.
- Send 0x3C with stop bit 0, line held low for 20 cycles, then high -> `regOutput` = 0x3C, `frameErr` = 1, and no new start is detected until the line goes high.
- `dataReady` = 0; send 0x11 then 0x22 -> `regOutput` stays 0x11 and `overrun` = 1. Pulse `dataReady` -> `dataValid` = 0 and `overrun` = 0.
- With `UART_RX_PARITY_EN`, `PARITY_ODD=0`: send 0x07 with parity bit 0 -> `parityErr` = 1. Send 0x07 with parity bit 1 -> `parityErr` = 0.
- Assert `rst` during data bit 4 of a frame, then send 0x5A -> only 0x5A is delivered; all outputs read 0 on the cycle after reset.
